// File: rtl/jtag_tap_responder.sv
`default_nettype none
// ============================================================================
// jtag_tap_responder: 1149.1 TAP with IDCODE, BYPASS, CONFREG and a USER DR
// channel; all JTAG pins are oversampled in the clk_i domain.
// Revision: 1.0
// ============================================================================
module jtag_tap_responder #(
    parameter int          IR_WIDTH     = 5,
    parameter logic [31:0] IDCODE_VALUE = 32'h249511C3,
    parameter int          CONF_WIDTH   = 9,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  jtag_tck_i,
    input  logic                  jtag_trst_ni,
    input  logic                  jtag_tms_i,
    input  logic                  jtag_tdi_i,
    output logic                  jtag_tdo_o,
    output logic [CONF_WIDTH-1:0] conf_reg_o,
    output logic [3:0]            tap_state_o,
    output logic                  user_sel_o,
    output logic                  user_capture_o,
    output logic                  user_shift_o,
    output logic                  user_update_o,
    output logic                  user_tdi_o,
    input  logic                  user_tdo_i
);

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SH_DR    = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SH_IR    = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(5'h01);
    localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(5'h04);
    localparam logic [IR_WIDTH-1:0] IR_CONFREG = IR_WIDTH'(5'h06);

    logic [SYNC_STAGES-1:0] tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync;
    logic [SYNC_STAGES-1:0] tdi_sync;
    logic [SYNC_STAGES-1:0] trst_sync;
    logic                   tck_prev;

    logic tck_s;
    logic tms_s;
    logic tdi_s;
    logic trst_s;
    logic tck_rise;
    logic tck_fall;

    tap_state_e            state;
    logic [IR_WIDTH-1:0]   ir;
    logic [IR_WIDTH-1:0]   ir_shift;
    logic [31:0]           idcode_shift;
    logic [CONF_WIDTH-1:0] conf_shift;
    logic                  bypass_shift;

    logic sel_idcode;
    logic sel_conf;
    logic sel_user;
    logic tdo_next;

    // TRST flops reset to asserted so the TAP stays in reset until the pin is seen high.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_prev  <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[SYNC_STAGES-2:0], jtag_tck_i};
            tms_sync  <= {tms_sync[SYNC_STAGES-2:0], jtag_tms_i};
            tdi_sync  <= {tdi_sync[SYNC_STAGES-2:0], jtag_tdi_i};
            trst_sync <= {trst_sync[SYNC_STAGES-2:0], jtag_trst_ni};
            tck_prev  <= tck_sync[SYNC_STAGES-1];
        end
    end

    assign tck_s    = tck_sync[SYNC_STAGES-1];
    assign tms_s    = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];
    assign trst_s   = trst_sync[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev;
    assign tck_fall = ~tck_s & tck_prev;

    assign sel_idcode  = (ir == IR_IDCODE);
    assign sel_conf    = (ir == IR_CONFREG);
    assign sel_user    = (ir == IR_USER);
    assign user_sel_o  = sel_user;
    assign tap_state_o = state;

    function automatic tap_state_e next_state(input tap_state_e cur, input logic tms);
        tap_state_e nxt;
        nxt = TLR;
        case (cur)
            TLR:      nxt = tms ? TLR    : RTI;
            RTI:      nxt = tms ? SEL_DR : RTI;
            SEL_DR:   nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR:   nxt = tms ? EX1_DR : SH_DR;
            SH_DR:    nxt = tms ? EX1_DR : SH_DR;
            EX1_DR:   nxt = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: nxt = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   nxt = tms ? UPD_DR : SH_DR;
            UPD_DR:   nxt = tms ? SEL_DR : RTI;
            SEL_IR:   nxt = tms ? TLR    : CAP_IR;
            CAP_IR:   nxt = tms ? EX1_IR : SH_IR;
            SH_IR:    nxt = tms ? EX1_IR : SH_IR;
            EX1_IR:   nxt = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: nxt = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   nxt = tms ? UPD_IR : SH_IR;
            UPD_IR:   nxt = tms ? SEL_DR : RTI;
            default:  nxt = TLR;
        endcase
        return nxt;
    endfunction

    always_comb begin
        tdo_next = 1'b0;
        if (state == SH_IR) begin
            tdo_next = ir_shift[0];
        end else if (state == SH_DR) begin
            if (sel_idcode)    tdo_next = idcode_shift[0];
            else if (sel_conf) tdo_next = conf_shift[0];
            else if (sel_user) tdo_next = user_tdo_i;
            else               tdo_next = bypass_shift;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state          <= TLR;
            ir             <= IR_IDCODE;
            ir_shift       <= '0;
            idcode_shift   <= '0;
            conf_shift     <= '0;
            bypass_shift   <= 1'b0;
            conf_reg_o     <= '0;
            jtag_tdo_o     <= 1'b0;
            user_capture_o <= 1'b0;
            user_shift_o   <= 1'b0;
            user_update_o  <= 1'b0;
            user_tdi_o     <= 1'b0;
        end else if (!trst_s) begin
            state          <= TLR;
            ir             <= IR_IDCODE;
            ir_shift       <= '0;
            idcode_shift   <= '0;
            conf_shift     <= '0;
            bypass_shift   <= 1'b0;
            conf_reg_o     <= '0;
            jtag_tdo_o     <= 1'b0;
            user_capture_o <= 1'b0;
            user_shift_o   <= 1'b0;
            user_update_o  <= 1'b0;
            user_tdi_o     <= 1'b0;
        end else begin
            user_capture_o <= 1'b0;
            user_shift_o   <= 1'b0;
            user_update_o  <= 1'b0;

            // Rising-edge actions depend on the state being left, not entered.
            if (tck_rise) begin
                user_tdi_o <= tdi_s;
                case (state)
                    CAP_IR: ir_shift <= IR_WIDTH'(2'b01);
                    SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
                    CAP_DR: begin
                        if (sel_idcode)    idcode_shift   <= IDCODE_VALUE;
                        else if (sel_conf) conf_shift     <= conf_reg_o;
                        else if (sel_user) user_capture_o <= 1'b1;
                        else               bypass_shift   <= 1'b0;
                    end
                    SH_DR: begin
                        if (sel_idcode)    idcode_shift <= {tdi_s, idcode_shift[31:1]};
                        else if (sel_conf) conf_shift   <= {tdi_s, conf_shift[CONF_WIDTH-1:1]};
                        else if (sel_user) user_shift_o <= 1'b1;
                        else               bypass_shift <= tdi_s;
                    end
                    default: ;
                endcase
                state <= next_state(state, tms_s);
            end

            if (tck_fall) begin
                jtag_tdo_o <= tdo_next;
                if (state == UPD_IR)
                    ir <= ir_shift;
                if (state == UPD_DR && sel_conf)
                    conf_reg_o <= conf_shift;
                if (state == UPD_DR && sel_user)
                    user_update_o <= 1'b1;
            end

            // Test-Logic-Reset reached through TMS restores IDCODE but leaves conf_reg_o.
            if (state == TLR)
                ir <= IR_IDCODE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_responder.sv
`default_nettype none
// Directed bench for jtag_tap_responder: bit-banged TCK at 1/10 of clk_i,
// with a small external user DR model.
module tb_jtag_tap_responder;

    logic       clk_i = 1'b0;
    logic       rst_n;
    logic       jtag_tck_i;
    logic       jtag_trst_ni;
    logic       jtag_tms_i;
    logic       jtag_tdi_i;
    logic       jtag_tdo_o;
    logic [8:0] conf_reg_o;
    logic [3:0] tap_state_o;
    logic       user_sel_o;
    logic       user_capture_o;
    logic       user_shift_o;
    logic       user_update_o;
    logic       user_tdi_o;
    logic       user_tdo_i;

    int errors = 0;
    int checks = 0;

    logic [31:0] user_hold = 32'h12345678;
    logic [31:0] user_dr   = 32'h0;
    logic [31:0] user_rx   = 32'h0;
    int          cap_cnt   = 0;
    int          shift_cnt = 0;
    int          upd_cnt   = 0;

    jtag_tap_responder dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .jtag_tck_i     (jtag_tck_i),
        .jtag_trst_ni   (jtag_trst_ni),
        .jtag_tms_i     (jtag_tms_i),
        .jtag_tdi_i     (jtag_tdi_i),
        .jtag_tdo_o     (jtag_tdo_o),
        .conf_reg_o     (conf_reg_o),
        .tap_state_o    (tap_state_o),
        .user_sel_o     (user_sel_o),
        .user_capture_o (user_capture_o),
        .user_shift_o   (user_shift_o),
        .user_update_o  (user_update_o),
        .user_tdi_o     (user_tdi_o),
        .user_tdo_i     (user_tdo_i)
    );

    always #5 clk_i = ~clk_i;

    assign user_tdo_i = user_dr[0];

    // External user DR: capture loads the held value, update stores the shifted value.
    always @(negedge clk_i) begin
        if (user_capture_o) begin
            cap_cnt <= cap_cnt + 1;
            user_dr <= user_hold;
        end
        if (user_shift_o) begin
            shift_cnt <= shift_cnt + 1;
            user_dr   <= {user_tdi_o, user_dr[31:1]};
            user_rx   <= {user_tdi_o, user_rx[31:1]};
        end
        if (user_update_o) begin
            upd_cnt   <= upd_cnt + 1;
            user_hold <= user_dr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One TCK period of 100 ns; TDO is sampled 50 ns after the previous falling edge.
    task automatic step(input logic tms, input logic tdi, output logic tdo);
        jtag_tms_i = tms;
        jtag_tdi_i = tdi;
        #10;
        tdo = jtag_tdo_o;
        jtag_tck_i = 1'b1;
        #50;
        jtag_tck_i = 1'b0;
        #40;
    endtask

    // From RTI, ends back in RTI.
    task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
        logic b;
        dout = '0;
        step(1'b1, 1'b0, b);
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            step(i == 4, din[i], b);
            dout[i] = b;
        end
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
    endtask

    // From RTI, ends right after the Update-DR falling edge.
    task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic b;
        dout = '0;
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], b);
            dout[i] = b;
        end
        step(1'b1, 1'b0, b);
    endtask

    initial begin
        logic        b;
        logic [4:0]  ir_out;
        logic [31:0] dr_out;
        int          cap0;
        int          shift0;
        int          upd0;

        rst_n        = 1'b0;
        jtag_trst_ni = 1'b1;
        jtag_tck_i   = 1'b0;
        jtag_tms_i   = 1'b0;
        jtag_tdi_i   = 1'b0;
        #20;
        check("reset_state", 32'(tap_state_o), 32'h0);
        check("reset_tdo", 32'(jtag_tdo_o), 32'h0);
        check("reset_conf", 32'(conf_reg_o), 32'h0);
        check("reset_strobes", 32'({user_capture_o, user_shift_o, user_update_o}), 32'h0);
        check("reset_user_sel", 32'(user_sel_o), 32'h0);
        #10;
        rst_n = 1'b1;
        #40;
        jtag_trst_ni = 1'b0;
        #50;
        jtag_trst_ni = 1'b1;
        #50;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, b);
        check("tlr_after_tms", 32'(tap_state_o), 32'h0);
        step(1'b0, 1'b0, b);
        check("rti", 32'(tap_state_o), 32'h1);

        shift_dr(32, 32'h0, dr_out);
        check("idcode", dr_out, 32'h249511C3);
        step(1'b0, 1'b0, b);

        shift_ir(5'h1F, ir_out);
        check("ir_capture", 32'(ir_out), 32'h01);
        shift_dr(4, 32'hD, dr_out);
        check("bypass_1101", dr_out, 32'hA);
        step(1'b0, 1'b0, b);

        shift_ir(5'h06, ir_out);
        shift_dr(9, 32'h002, dr_out);
        check("conf_first_capture", dr_out, 32'h0);
        check("conf_update_latency", 32'(conf_reg_o), 32'h002);
        step(1'b0, 1'b0, b);
        shift_dr(9, 32'h000, dr_out);
        check("conf_readback", dr_out, 32'h002);
        check("conf_after_zero_scan", 32'(conf_reg_o), 32'h000);
        step(1'b0, 1'b0, b);
        shift_dr(9, 32'h002, dr_out);
        step(1'b0, 1'b0, b);
        check("conf_rewrite", 32'(conf_reg_o), 32'h002);

        // CapDR -> Exit1 -> Update without shifting.
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b1, 1'b0, b);
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        check("conf_update_no_shift", 32'(conf_reg_o), 32'h002);

        shift_ir(5'h1F, ir_out);
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
        check("in_shdr", 32'(tap_state_o), 32'h4);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, b);
        check("tms_reset_state", 32'(tap_state_o), 32'h0);
        check("tms_reset_keeps_conf", 32'(conf_reg_o), 32'h002);
        step(1'b0, 1'b0, b);
        shift_dr(32, 32'h0, dr_out);
        check("tms_reset_ir_idcode", dr_out, 32'h249511C3);
        step(1'b0, 1'b0, b);

        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
        check("pre_trst_tdo", 32'(jtag_tdo_o), 32'h1);
        jtag_trst_ni = 1'b0;
        #60;
        check("trst_conf", 32'(conf_reg_o), 32'h0);
        check("trst_tdo", 32'(jtag_tdo_o), 32'h0);
        check("trst_state", 32'(tap_state_o), 32'h0);
        step(1'b0, 1'b0, b);
        check("trst_held", 32'(tap_state_o), 32'h0);
        jtag_trst_ni = 1'b1;
        #40;

        step(1'b0, 1'b0, b);
        shift_ir(5'h04, ir_out);
        check("user_sel", 32'(user_sel_o), 32'h1);
        cap0   = cap_cnt;
        shift0 = shift_cnt;
        upd0   = upd_cnt;
        shift_dr(32, 32'hABBAABBA, dr_out);
        step(1'b0, 1'b0, b);
        check("user_tdo_stream", dr_out, 32'h12345678);
        check("user_captures", 32'(cap_cnt - cap0), 32'd1);
        check("user_shifts", 32'(shift_cnt - shift0), 32'd32);
        check("user_updates", 32'(upd_cnt - upd0), 32'd1);
        check("user_tdi_bits", user_rx, 32'hABBAABBA);
        check("user_dr_updated", user_hold, 32'hABBAABBA);

        shift_ir(5'h0A, ir_out);
        check("ir_capture_2", 32'(ir_out), 32'h01);
        check("unknown_not_user", 32'(user_sel_o), 32'h0);
        shift_dr(4, 32'hD, dr_out);
        check("unknown_bypass", dr_out, 32'hA);
        step(1'b0, 1'b0, b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
